// File: rtl/mem_stage_if.sv
// Data-memory handshake between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
    localparam int unsigned DATA_W = 32;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on a variable-latency data-memory
// handshake, stalls the pipe while an access is outstanding, and registers the
// MEM/WB values. Timed-out accesses raise a sticky bus-error flag.
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned accesses as bus errors.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    mem_stage_if.master dmem,
    output logic        Stall_MEM,
    output logic [31:0] ReadData_MEM,
    output logic [31:0] Result_MEM,
    output logic [4:0]  WriteReg_MEM,
    output logic        RegWrite_MEM,
    output logic        MemToReg_MEM,
    output logic        MemErr_MEM
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             op;
    logic             misaligned;
    logic             timeout;
    logic             memReq;
    logic             stall;
    logic             bubble;
    logic             setErr;

    assign op = MemToReg_EX | MemWrite_EX;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = op & (|Result_EX[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // waitCnt counts completed WAIT/DRAIN cycles; the cycle in which it would
    // reach MAX_WAIT is the last one the access is allowed.
    assign timeout = (waitCnt == CNT_W'(MAX_WAIT - 1));

    // Next-state and handshake/stall decode.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        memReq      = 1'b0;
        stall       = 1'b0;
        bubble      = 1'b0;
        setErr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (misaligned) begin
                    setErr = 1'b1;
                    bubble = 1'b1;
                end else if (op) begin
                    memReq = 1'b1;
                    if (!dmem.dmem_ack) begin
                        stall       = 1'b1;
                        waitCntNext = '0;
                        // A request already on the bus must complete even if squashed.
                        stateNext   = flush ? DRAIN : WAIT;
                    end
                end
            end
            WAIT: begin
                memReq      = 1'b1;
                waitCntNext = waitCnt + CNT_W'(1);
                if (dmem.dmem_ack) begin
                    stateNext = IDLE;
                end else if (timeout) begin
                    setErr    = 1'b1;
                    bubble    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                    if (flush) begin
                        stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                memReq      = 1'b1;
                stall       = 1'b1;
                waitCntNext = waitCnt + CNT_W'(1);
                if (dmem.dmem_ack) begin
                    stateNext = IDLE;
                end else if (timeout) begin
                    setErr    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Bus and stall outputs are combinational; forced low while in reset.
    assign dmem.dmem_req   = memReq & rst_n;
    assign dmem.dmem_we    = MemWrite_EX;
    assign dmem.dmem_addr  = {Result_EX[DATA_W-1:2], 2'b00};
    assign dmem.dmem_wdata = WrDat_EX;
    assign Stall_MEM       = stall & rst_n;

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // MEM/WB register: flush clears, stalls/aborts insert a bubble, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData_MEM <= '0;
            Result_MEM   <= '0;
            WriteReg_MEM <= '0;
            RegWrite_MEM <= 1'b0;
            MemToReg_MEM <= 1'b0;
        end else if (flush) begin
            ReadData_MEM <= '0;
            Result_MEM   <= '0;
            WriteReg_MEM <= '0;
            RegWrite_MEM <= 1'b0;
            MemToReg_MEM <= 1'b0;
        end else if (stall | bubble) begin
            RegWrite_MEM <= 1'b0;
            MemToReg_MEM <= 1'b0;
        end else begin
            Result_MEM   <= Result_EX;
            WriteReg_MEM <= WriteReg_EX[REG_W-1:0];
            RegWrite_MEM <= RegWrite_EX;
            MemToReg_MEM <= MemToReg_EX;
            if (MemToReg_EX) begin
                ReadData_MEM <= dmem.dmem_rdata;
            end
        end
    end

    // Sticky bus-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemErr_MEM <= 1'b0;
        end else if (setErr) begin
            MemErr_MEM <= 1'b1;
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of the execute stage; consumes the EX/MEM outputs (ALU result, store data, write register, control bits).
- Performs load/store accesses on a variable-latency data-memory handshake and raises Stall_MEM while an access is outstanding.
- Registers the MEM/WB pipeline values for the writeback stage.

Parameters:
- MAX_WAIT, 15: maximum WAIT cycles before an access is aborted as a bus error (1..255).
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the MEM/WB register.
- Result_EX  in  32  ALU result; memory byte address for loads/stores.
- WrDat_EX  in  32  store data.
- WriteReg_EX  in  5  destination register.
- RegWrite_EX  in  1  register write enable.
- MemToReg_EX  in  1  load.
- MemWrite_EX  in  1  store.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- Stall_MEM  out  1  to the hazard unit (ORed into AnyStall).
- ReadData_MEM  out  32  registered load data.
- Result_MEM  out  32  registered ALU result.
- WriteReg_MEM  out  5  registered destination register.
- RegWrite_MEM  out  1  registered write enable.
- MemToReg_MEM  out  1  registered load select.
- MemErr_MEM  out  1  sticky bus-error flag; cleared only by reset.

Behaviour:
- Access condition: op = MemToReg_EX | MemWrite_EX. Upstream holds its inputs stable while Stall_MEM=1.
- Reset (async, rst_n=0): FSM to IDLE; wait counter 0; all registered outputs 0; MemErr_MEM 0.
- dmem_req = op in IDLE, and 1 in WAIT and DRAIN. It is combinational.
- dmem_we = MemWrite_EX. dmem_addr = {Result_EX[31:2],2'b00}. dmem_wdata = WrDat_EX.
- FSM IDLE:
  - op=0: pass-through; the MEM/WB register loads next cycle; Stall_MEM=0.
  - op=1 and dmem_ack=1: zero-wait access; the MEM/WB register captures dmem_rdata; no stall.
  - op=1 and dmem_ack=0: go to WAIT; Stall_MEM=1; counter cleared.
- FSM WAIT:
  - Stall_MEM = !dmem_ack; counter increments each cycle.
  - On ack: the MEM/WB register captures data, Stall_MEM=0 that cycle, return to IDLE.
  - If the counter reaches MAX_WAIT without ack: abort. Set MemErr_MEM, load a bubble (RegWrite_MEM=0), deassert dmem_req next cycle, return to IDLE, Stall_MEM=0.
- FSM DRAIN: entered when flush=1 while in WAIT.
  - Keeps dmem_req high until dmem_ack (or timeout), then returns to IDLE.
  - Stall_MEM=1 throughout.
  - The result is discarded; a bubble is loaded on exit.
- MEM/WB register:
  - Loads on every cycle with Stall_MEM=0.
  - On a Stall_MEM=1 cycle it loads a bubble (RegWrite_MEM=0, MemToReg_MEM=0; other fields hold), so writeback never repeats an instruction.
  - flush=1 clears all fields to 0 and takes priority over a load.
- ReadData_MEM is loaded only for completed loads; it holds otherwise.
- Simultaneous flush with dmem_ack in WAIT: the access completes, the result is discarded (bubble), and the FSM goes to IDLE.
- Timeout and ack in the same cycle: ack wins.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: an op with Result_EX[1:0]!=0 issues no dmem_req. It sets MemErr_MEM, loads a bubble, and causes no stall.
- Undefined: low address bits are ignored and the access proceeds on the aligned word.

Test Plan:
- Reset mid-WAIT: rst_n low while in WAIT -> all outputs 0, dmem_req 0, FSM IDLE immediately (asynchronous).
- Zero-wait load: Result_EX=0x100, MemToReg_EX=1, RegWrite_EX=1, WriteReg_EX=5, ack same cycle with rdata=0xDEADBEEF -> no stall. Next cycle ReadData_MEM=0xDEADBEEF, WriteReg_MEM=5, RegWrite_MEM=1.
- Three-wait store: MemWrite_EX=1, addr 0x200, data 0x12345678, ack on the 4th cycle:
  - dmem_req/dmem_we held 4 cycles.
  - Stall_MEM=1 for 3 cycles.
  - RegWrite_MEM=0 throughout.
- Timeout with MAX_WAIT=4 and no ack:
  - Stall_MEM high 4 cycles, then MemErr_MEM=1.
  - dmem_req drops.
  - A following ALU op (RegWrite_EX=1, Result_EX=7) passes through unchanged.
- Flush in WAIT:
  - flush pulse at WAIT cycle 2, ack at cycle 5 -> Stall_MEM high until ack.
  - RegWrite_MEM stays 0 and the load data is discarded.
- Alignment (MEM_ALIGN_CHECK_EN defined): load at 0x102 -> dmem_req never asserted, MemErr_MEM=1, no stall.
